// File: rtl/sprite_compositor_if.sv
// Sprite ROM bus: per-channel texel address out of the compositor, RGB565 texel back.
interface sprite_compositor_if #(
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned ROM_AW      = 17
);
  logic [ROM_AW*NUM_SPRITES-1:0] rom_addr;
  logic [16*NUM_SPRITES-1:0]     rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: two-stage hit/ROM-address pipeline with priority and
// colour-key resolve, plus a per-channel animation sequencer (loop / one-shot).
module sprite_compositor #(
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned SPRITE_W    = 64,
  parameter int unsigned SPRITE_H    = 64,
  parameter int unsigned NUM_ANIMS   = 8,
  parameter int unsigned NUM_FRAMES  = 4,
  parameter int unsigned FRAME_TICKS = 8,
  parameter logic [15:0] TRANSPARENT = 16'hF81F,
  parameter logic [7:0]  BG_COLOR    = 8'h00,
  localparam int unsigned AW     = $clog2(NUM_ANIMS),
  localparam int unsigned FW     = $clog2(NUM_FRAMES),
  localparam int unsigned XW     = $clog2(SPRITE_W),
  localparam int unsigned YW     = $clog2(SPRITE_H),
  localparam int unsigned TW     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1,
  localparam int unsigned ROM_AW = AW + FW + YW + XW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [9:0]                    pixel_x,
  input  logic [9:0]                    pixel_y,
  input  logic                          frame_tick,
  input  logic [NUM_SPRITES-1:0]        spr_en,
  input  logic [10*NUM_SPRITES-1:0]     spr_x,
  input  logic [10*NUM_SPRITES-1:0]     spr_y,
  input  logic [NUM_SPRITES-1:0]        spr_flip,
  input  logic [AW*NUM_SPRITES-1:0]     anim_sel,
  input  logic [NUM_SPRITES-1:0]        anim_oneshot,
  sprite_compositor_if.master           rom_bus,
  output logic [NUM_SPRITES-1:0]        anim_done,
  output logic [7:0]                    color_out
);

  typedef enum logic {RUN, HOLD} anim_state_e;

  logic [NUM_SPRITES-1:0]        hit_d, hit_q;
  logic [ROM_AW*NUM_SPRITES-1:0] rom_addr_d, rom_addr_q;
  logic [7:0]                    color_d, color_q;
  logic [10:0]                   dx [NUM_SPRITES];
  logic [10:0]                   dy [NUM_SPRITES];
  logic [XW-1:0]                 col [NUM_SPRITES];
  logic                          won;

  anim_state_e                   state_d [NUM_SPRITES];
  anim_state_e                   state_q [NUM_SPRITES];
  logic [FW-1:0]                 frame_d [NUM_SPRITES];
  logic [FW-1:0]                 frame_q [NUM_SPRITES];
  logic [TW-1:0]                 tick_d  [NUM_SPRITES];
  logic [TW-1:0]                 tick_q  [NUM_SPRITES];
  logic [AW*NUM_SPRITES-1:0]     anim_prev_d, anim_prev_q;
  logic [NUM_SPRITES-1:0]        oneshot_prev_d, oneshot_prev_q;
  logic [NUM_SPRITES-1:0]        anim_done_d, anim_done_q;

  function automatic logic [7:0] rgb565_to_332(input logic [15:0] t);
    return {t[15:13], t[10:8], t[4:3]};
  endfunction

  // S1: 11-bit differences so a negative offset lands far above the sprite size
  always_comb begin
    hit_d      = '0;
    rom_addr_d = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      dx[i]  = {1'b0, pixel_x} - {1'b0, spr_x[10*i +: 10]};
      dy[i]  = {1'b0, pixel_y} - {1'b0, spr_y[10*i +: 10]};
      col[i] = spr_flip[i] ? XW'(SPRITE_W - 1) - dx[i][XW-1:0] : dx[i][XW-1:0];
      hit_d[i] = spr_en[i] && (dx[i] < 11'(SPRITE_W)) && (dy[i] < 11'(SPRITE_H));
      rom_addr_d[ROM_AW*i +: ROM_AW] =
        {anim_sel[AW*i +: AW], frame_q[i], dy[i][YW-1:0], col[i]};
    end
  end

  // S2: lowest-index opaque hit wins
  always_comb begin
    color_d = BG_COLOR;
    won     = 1'b0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (!won && hit_q[i] && (rom_bus.rom_data[16*i +: 16] != TRANSPARENT)) begin
        color_d = rgb565_to_332(rom_bus.rom_data[16*i +: 16]);
        won     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q      <= '0;
      rom_addr_q <= '0;
      color_q    <= BG_COLOR;
    end else begin
      hit_q      <= hit_d;
      rom_addr_q <= rom_addr_d;
      color_q    <= color_d;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        state_q[i] <= RUN;
        frame_q[i] <= '0;
        tick_q[i]  <= '0;
      end
      anim_prev_q    <= '0;
      oneshot_prev_q <= '0;
      anim_done_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        state_q[i] <= state_d[i];
        frame_q[i] <= frame_d[i];
        tick_q[i]  <= tick_d[i];
      end
      anim_prev_q    <= anim_prev_d;
      oneshot_prev_q <= oneshot_prev_d;
      anim_done_q    <= anim_done_d;
    end
  end

  // Sequencer next state: an animation change outranks everything, including a tick
  always_comb begin
    anim_prev_d    = anim_sel;
    oneshot_prev_d = anim_oneshot;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      state_d[i] = state_q[i];
      frame_d[i] = frame_q[i];
      tick_d[i]  = tick_q[i];
      if (anim_sel[AW*i +: AW] != anim_prev_q[AW*i +: AW]) begin
        state_d[i] = RUN;
        frame_d[i] = '0;
        tick_d[i]  = '0;
      end else if (state_q[i] == HOLD) begin
        if (oneshot_prev_q[i] && !anim_oneshot[i]) state_d[i] = RUN;
      end else if (frame_tick) begin
        if (tick_q[i] == TW'(FRAME_TICKS - 1)) begin
          tick_d[i]  = '0;
          frame_d[i] = frame_q[i] + FW'(1);
          if (anim_oneshot[i] && (frame_d[i] == '1)) state_d[i] = HOLD;
        end else begin
          tick_d[i] = tick_q[i] + TW'(1);
        end
      end
    end
  end

  // Sequencer outputs
  always_comb begin
    anim_done_d = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      anim_done_d[i] = (state_q[i] == RUN) && (state_d[i] == HOLD);
    end
  end

  assign rom_bus.rom_addr = rom_addr_q;
  assign color_out        = color_q;
  assign anim_done        = anim_done_q;

endmodule
